// File: rtl/ic_rand_victim_sel_pkg.sv
// Shared types and helpers for the I-cache random victim selector.
// Helpers work on the widest legal set and are narrowed by the caller.
package ic_rand_victim_sel_pkg;

  localparam int MAX_WAYS  = 8;
  localparam int MAX_IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  function automatic logic [MAX_IDX_W-1:0] lowest_zero_idx(
    input logic [MAX_WAYS-1:0] mask,
    input int                  n
  );
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = MAX_WAYS - 1; i >= 0; i--) begin
      if (i < n && !mask[i]) idx = MAX_IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [MAX_WAYS-1:0] idx2oh(
    input logic [MAX_IDX_W-1:0] idx
  );
    return MAX_WAYS'(1) << idx;
  endfunction

endpackage

// File: rtl/ic_rand_victim_sel_rand_pool_fifo.sv
// Small synchronous FIFO holding pre-drawn random way indices.
// Sole owner of the read/write pointers and the occupancy counter.
module rand_pool_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [W-1:0]                 din,
  input  logic                         pop,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [W-1:0]                 head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head = mem[rd_ptr];

  // Storage array, written only on a live push.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; flush empties in one cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= inc(wr_ptr);
      if (pop)  rd_ptr <= inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ic_rand_victim_sel.sv
// Random-replacement victim selector for the I-cache (MBPTA mode).
// Invalid ways win; otherwise a pre-filtered random index is popped.
module ic_rand_victim_sel
  import ic_rand_victim_sel_pkg::*;
#(
  parameter int NUM_WAYS   = 4,
  parameter int POOL_DEPTH = 4,
  localparam int IDX_W     = $clog2(NUM_WAYS),
  localparam int CNT_W     = $clog2(POOL_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rnd_en_i,
  input  logic [IDX_W-1:0]    rnd_i,
  input  logic                flush_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [NUM_WAYS-1:0] req_vld_ways_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [IDX_W-1:0]    rsp_way_o,
  output logic [NUM_WAYS-1:0] rsp_way_oh_o,
  output logic                rsp_rand_o,
  output logic [CNT_W-1:0]    pool_cnt_o
);

  state_e           state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] effcnt;
  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] inv_way;
  logic             all_valid;
  logic             rnd_ok;
  logic             avail;
  logic             accept;
  logic             push;
  logic             pop;

  assign rnd_ok    = {1'b0, rnd_i} < (IDX_W + 1)'(NUM_WAYS);
  assign effcnt    = flush_i ? '0 : count;
  assign avail     = effcnt != '0;
  assign all_valid = &req_vld_ways_i;
  assign inv_way   = IDX_W'(lowest_zero_idx(MAX_WAYS'(req_vld_ways_i),
                                            NUM_WAYS));

  assign req_ready_o = (state == ST_IDLE) && !rst;
  assign accept      = req_valid_i && req_ready_o;

  assign pop  = avail && ((accept && all_valid) ||
                          (state == ST_WAIT && !rst));
  assign push = rnd_en_i && rnd_ok && !flush_i &&
                ((count != CNT_W'(POOL_DEPTH)) || pop);

  assign pool_cnt_o = count;

  rand_pool_fifo #(
    .W     (IDX_W),
    .DEPTH (POOL_DEPTH)
  ) u_pool (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (rnd_i),
    .pop   (pop),
    .flush (flush_i),
    .count (count),
    .head  (head)
  );

  // Request FSM with registered response fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      rsp_valid_o  <= 1'b0;
      rsp_way_o    <= '0;
      rsp_way_oh_o <= '0;
      rsp_rand_o   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            if (!all_valid) begin
              state        <= ST_RESP;
              rsp_valid_o  <= 1'b1;
              rsp_way_o    <= inv_way;
              rsp_way_oh_o <= NUM_WAYS'(idx2oh(MAX_IDX_W'(inv_way)));
              rsp_rand_o   <= 1'b0;
            end else if (avail) begin
              state        <= ST_RESP;
              rsp_valid_o  <= 1'b1;
              rsp_way_o    <= head;
              rsp_way_oh_o <= NUM_WAYS'(idx2oh(MAX_IDX_W'(head)));
              rsp_rand_o   <= 1'b1;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (avail) begin
            state        <= ST_RESP;
            rsp_valid_o  <= 1'b1;
            rsp_way_o    <= head;
            rsp_way_oh_o <= NUM_WAYS'(idx2oh(MAX_IDX_W'(head)));
            rsp_rand_o   <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            state       <= ST_IDLE;
            rsp_valid_o <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ic_rand_victim_sel.md
Name: ic_rand_victim_sel

Overview:
- Random-replacement victim selector for the I-cache in the MBPTA configuration. Sits directly downstream of the LFSR PRNG and consumes its free-running output every cycle.
- Keeps a small pool of pre-filtered random way indices. Uses them to answer victim requests from the I-cache miss FSM.
- A way that is not valid is always chosen before a random way.

Parameters:
- NUM_WAYS, 4, number of cache ways; legal range 2..8.
- POOL_DEPTH, 4, number of pre-drawn random indices held; legal range 2..8.
- Derived localparams: IDX_W = $clog2(NUM_WAYS); CNT_W = $clog2(POOL_DEPTH+1).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- rnd_en_i  in  1  PRNG output is valid this cycle
- rnd_i  in  IDX_W  low bits of the PRNG output
- flush_i  in  1  discard pool contents (asserted on reseed)
- req_valid_i  in  1  victim request
- req_ready_o  out  1  request accepted when req_valid_i and req_ready_o are both high
- req_vld_ways_i  in  NUM_WAYS  valid bits of the target set
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_way_o  out  IDX_W  victim way index
- rsp_way_oh_o  out  NUM_WAYS  victim way, one-hot
- rsp_rand_o  out  1  1 = way chosen randomly; 0 = way chosen because it was invalid
- pool_cnt_o  out  CNT_W  current pool occupancy (debug)

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- Reset values:
  - FSM in IDLE, pool empty, pointers 0.
  - rsp_valid_o=0, rsp_way_o=0, rsp_way_oh_o=0, rsp_rand_o=0, pool_cnt_o=0.
  - req_ready_o=0 while rst is high; 1 in the first cycle after.
- Pool fill:
  - Each cycle, push rnd_i iff rnd_en_i=1, rnd_i < NUM_WAYS, flush_i=0, and the pool is not full or is popped in the same cycle.
  - Values >= NUM_WAYS are rejected (rejection sampling); this never happens when NUM_WAYS is a power of 2.
  - A pushed entry becomes poppable in the next cycle. There is no bypass path.
- Flush: pointers and count are cleared that cycle. Any push in that cycle is dropped. The pool is treated as empty for any pop decision in that cycle.
- Effective count: effcnt = flush_i ? 0 : count.
- FSM IDLE (req_ready_o=1). On accept, the set-valid mask is evaluated that cycle:
  - Any valid bit is 0 → load the lowest-index invalid way, rsp_rand_o=0, no pop, go to RESP.
  - All ways valid and effcnt > 0 → pop the head entry, load it, rsp_rand_o=1, go to RESP.
  - All ways valid and effcnt = 0 → go to WAIT.
- FSM WAIT (req_ready_o=0): when effcnt > 0, pop, load the way, rsp_rand_o=1, go to RESP.
- FSM RESP (rsp_valid_o=1, req_ready_o=0):
  - rsp_way_o, rsp_way_oh_o and rsp_rand_o are registered and held stable.
  - On rsp_ready_i=1 → IDLE. The next request can be accepted in the following cycle.
- Latency: response valid 1 cycle after accept when a way is invalid or the pool is non-empty. Otherwise 1 cycle after the first poppable entry arrives.
- Pool fill continues in every FSM state.
- rsp_way_oh_o always equals 1 << rsp_way_o while rsp_valid_o=1.
- pool_cnt_o is the registered count and never exceeds POOL_DEPTH.
- Reset asserted mid-operation aborts any pending request with no response. All reset values apply in the next cycle.

Decomposition:
- Shared package gets:
  - the FSM state enum (IDLE, WAIT, RESP)
  - helper function lowest_zero_idx (NUM_WAYS mask → index)
  - helper function idx2oh
- One sub-module: rand_pool_fifo. It is a parameterised synchronous FIFO (push, pop, flush, count, head) that is the single owner of the pointers and the counter.

Test Plan:
- Fill and overflow: NUM_WAYS=4, POOL_DEPTH=4, stream 2,1,3,0,1 with rnd_en_i=1 → pool_cnt_o=4 and the 5th value is dropped. Then a request with mask 1111 → next cycle rsp_way_o=2, rsp_way_oh_o=0100, rsp_rand_o=1, pool_cnt_o=3.
- Invalid-way priority: pool holds 3 entries, request with mask 1011 → rsp_way_o=2, rsp_rand_o=0, pool_cnt_o stays 3.
- Empty pool: rnd_en_i=0, request with mask 1111 at cycle t → WAIT, req_ready_o=0. Then rnd_i=1 at t+3 → pop at t+4, rsp_valid_o=1 at t+5 with rsp_way_o=1.
- Rejection: NUM_WAYS=3, stream 3,3,2 → only 2 is pushed, pool_cnt_o=1. A request with mask 111 → rsp_way_o=2.
- Backpressure: hold rsp_ready_i=0 for 5 cycles in RESP with stream 0,1,2 → outputs stable, req_ready_o=0, pool_cnt_o grows by 3. Releasing rsp_ready_i returns to IDLE the next cycle.
- Flush and reset:
  - Pool=3 with flush_i and a valid push in the same cycle → pool_cnt_o=0 next cycle.
  - A request with mask 1111 in a flush cycle → WAIT.
  - rst asserted during RESP → rsp_valid_o=0 and pool_cnt_o=0 next cycle.
